// File: rtl/intpol2_d4_diff_seq.sv
// Forward-difference sequencer for the intpol2_D4 datapath: d1=y1-y0, d2=y2-y1, dd=d2-d1 on one shared registered subtractor.
// Optional one-deep job buffer enabled by defining INTPOL2_D4_DIFF_START_BUF_EN.
module intpol2_d4_diff_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int N_bits     = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        y0,
  input  logic [DATA_WIDTH-1:0]        y1,
  input  logic [DATA_WIDTH-1:0]        y2,
  output logic                         busy,
  output logic                         done,
  output logic [DATA_WIDTH+N_bits-1:0] d1,
  output logic [DATA_WIDTH+N_bits-1:0] d2,
  output logic [DATA_WIDTH+N_bits-1:0] dd,
  output logic                         sub_en,
  output logic [DATA_WIDTH+N_bits-1:0] sub_A,
  output logic [DATA_WIDTH+N_bits-1:0] sub_B,
  input  logic [DATA_WIDTH+N_bits-1:0] sub_C
);

  localparam int W = DATA_WIDTH + N_bits;

  typedef enum logic [2:0] {IDLE, D1, D2, DD, FIN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   y0_q, y0_d, y1_q, y1_d, y2_q, y2_d;
  logic [W-1:0]   d1r_q, d1r_d, d2r_q, d2r_d;
  logic [W-1:0]   d1_q, d1_d, d2_q, d2_d, dd_q, dd_d;
  logic           done_q, done_d;
  logic [W-1:0]   y0_ext, y1_ext, y2_ext;

  assign y0_ext = {{N_bits{y0[DATA_WIDTH-1]}}, y0};
  assign y1_ext = {{N_bits{y1[DATA_WIDTH-1]}}, y1};
  assign y2_ext = {{N_bits{y2[DATA_WIDTH-1]}}, y2};

`ifdef INTPOL2_D4_DIFF_START_BUF_EN
  logic [W-1:0]   buf0_q, buf0_d, buf1_q, buf1_d, buf2_q, buf2_d;
  logic           pending_q, pending_d;
`endif

  always_comb begin
    state_d = state_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    d1r_d   = d1r_q;
    d2r_d   = d2r_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    dd_d    = dd_q;
    done_d  = 1'b0;
    sub_en  = 1'b0;
    sub_A   = '0;
    sub_B   = '0;
`ifdef INTPOL2_D4_DIFF_START_BUF_EN
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf2_d    = buf2_q;
    pending_d = pending_q;
    // A start that arrives mid-job parks its samples until FIN hands them over.
    if (start && !pending_q && (state_q == D1 || state_q == D2 || state_q == DD)) begin
      buf0_d    = y0_ext;
      buf1_d    = y1_ext;
      buf2_d    = y2_ext;
      pending_d = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          y0_d    = y0_ext;
          y1_d    = y1_ext;
          y2_d    = y2_ext;
          state_d = D1;
        end
      end
      D1: begin
        sub_en  = 1'b1;
        sub_A   = y1_q;
        sub_B   = y0_q;
        state_d = D2;
      end
      D2: begin
        sub_en  = 1'b1;
        sub_A   = y2_q;
        sub_B   = y1_q;
        d1r_d   = sub_C;
        state_d = DD;
      end
      DD: begin
        // d2 is still in the subtractor's output register, so it is forwarded rather than stored first.
        sub_en  = 1'b1;
        sub_A   = sub_C;
        sub_B   = d1r_q;
        d2r_d   = sub_C;
        state_d = FIN;
      end
      FIN: begin
        d1_d    = d1r_q;
        d2_d    = d2r_q;
        dd_d    = sub_C;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef INTPOL2_D4_DIFF_START_BUF_EN
        if (pending_q) begin
          y0_d      = buf0_q;
          y1_d      = buf1_q;
          y2_d      = buf2_q;
          pending_d = 1'b0;
          state_d   = D1;
        end else if (start) begin
          y0_d    = y0_ext;
          y1_d    = y1_ext;
          y2_d    = y2_ext;
          state_d = D1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      d1r_q   <= '0;
      d2r_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      dd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      d1r_q   <= d1r_d;
      d2r_q   <= d2r_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      dd_q    <= dd_d;
      done_q  <= done_d;
    end
  end

`ifdef INTPOL2_D4_DIFF_START_BUF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf0_q    <= '0;
      buf1_q    <= '0;
      buf2_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      buf2_q    <= buf2_d;
      pending_q <= pending_d;
    end
  end
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign d1   = d1_q;
  assign d2   = d2_q;
  assign dd   = dd_q;

endmodule

// File: tb/tb_intpol2_d4_diff_seq.sv
// Self-checking bench for intpol2_d4_diff_seq: spec vectors, random jobs against an arithmetic model, and
// hand sequences for start-while-busy, back-to-back and mid-job reset.
module tb_intpol2_d4_diff_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic [31:0] y0 = '0, y1 = '0, y2 = '0;
  logic        busy, done, sub_en;
  logic [33:0] d1, d2, dd, sub_a, sub_b;
  logic [33:0] sub_c;

  int nChecks = 0;
  int nFail   = 0;

  intpol2_d4_diff_seq #(.DATA_WIDTH(32), .N_bits(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .y0(y0), .y1(y1), .y2(y2),
    .busy(busy), .done(done), .d1(d1), .d2(d2), .dd(dd),
    .sub_en(sub_en), .sub_A(sub_a), .sub_B(sub_b), .sub_C(sub_c)
  );

  always #5 clk = ~clk;

  // Shared subtractor: registered A-B, holds its value when not enabled.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) sub_c <= '0;
    else if (sub_en) sub_c <= sub_a - sub_b;
  end

  typedef struct {
    logic [31:0] y0;
    logic [31:0] y1;
    logic [31:0] y2;
    longint      e1;
    longint      e2;
    longint      edd;
  } vec_t;

  vec_t vecs[4];

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    start = s;
    y0 = a;
    y1 = b;
    y2 = c;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint sx(input logic [33:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: the three differences straight from signed sample arithmetic.
  task automatic refDiffs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          output longint e1, output longint e2, output longint edd);
    longint la, lb, lc;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    lc  = longint'($signed(c));
    e1  = lb - la;
    e2  = lc - lb;
    edd = e2 - e1;
  endtask

  task automatic runJob(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input longint e1, input longint e2, input longint edd);
    int doneAt = 0;
    int subEnCnt = 0;
    @(negedge clk);
    applyStimulus(1'b1, a, b, c);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1'b0, $urandom, $urandom, $urandom);
      if (sub_en) subEnCnt++;
      else checkOutput({name, " subAB zero"}, longint'(sub_a | sub_b), 0);
      if (doneAt != 0 && k == doneAt + 1) begin
        checkOutput({name, " done width"}, longint'(done), 0);
        checkOutput({name, " d1 hold"}, sx(d1), e1);
        break;
      end
      if (done && doneAt == 0) begin
        doneAt = k;
        checkOutput({name, " d1"}, sx(d1), e1);
        checkOutput({name, " d2"}, sx(d2), e2);
        checkOutput({name, " dd"}, sx(dd), edd);
        checkOutput({name, " busy in done"}, longint'(busy), 0);
      end
    end
    checkOutput({name, " latency"}, longint'(doneAt), 5);
    checkOutput({name, " sub_en cycles"}, longint'(subEnCnt), 3);
  endtask

  initial begin
    longint e1, e2, edd;
    logic [31:0] a, b, c;
    int nDone, firstAt, secondAt;
    longint r1a, r2a, rda, r1b, r2b, rdb;

    vecs[0] = '{32'd10, 32'd25, 32'd55, 64'sd15, 64'sd30, 64'sd15};
    vecs[1] = '{32'd100, 32'd40, -32'sd50, -64'sd60, -64'sd90, -64'sd30};
    vecs[2] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, -64'sd4294967295, 64'sd4294967295, 64'sd8589934590};
    vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 64'sd4294967295, -64'sd4294967295, -64'sd8589934590};

    #1 rstn = 1'b0;
    #12;
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset d1", sx(d1), 0);
    checkOutput("reset dd", sx(dd), 0);
    checkOutput("reset sub_en", longint'(sub_en), 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 4; i++)
      runJob($sformatf("vec%0d", i), vecs[i].y0, vecs[i].y1, vecs[i].y2, vecs[i].e1, vecs[i].e2, vecs[i].edd);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      refDiffs(a, b, c, e1, e2, edd);
      runJob($sformatf("rand%0d", i), a, b, c, e1, e2, edd);
    end

    // Second start during D2 of a running job.
    nDone = 0; firstAt = 0; secondAt = 0;
    r1a = 0; r2a = 0; rda = 0; r1b = 0; r2b = 0; rdb = 0;
    @(negedge clk);
    applyStimulus(1'b1, 32'd10, 32'd25, 32'd55);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1'b0, $urandom, $urandom, $urandom);
      if (k == 2) applyStimulus(1'b1, 32'd1, 32'd2, 32'd4);
      if (k == 3) applyStimulus(1'b0, $urandom, $urandom, $urandom);
      if (done) begin
        nDone++;
        if (nDone == 1) begin firstAt = k; r1a = sx(d1); r2a = sx(d2); rda = sx(dd); end
        if (nDone == 2) begin secondAt = k; r1b = sx(d1); r2b = sx(d2); rdb = sx(dd); end
      end
    end
    checkOutput("busy-start first done", longint'(firstAt), 5);
    checkOutput("busy-start job1 d1", r1a, 15);
    checkOutput("busy-start job1 d2", r2a, 30);
    checkOutput("busy-start job1 dd", rda, 15);
`ifdef INTPOL2_D4_DIFF_START_BUF_EN
    checkOutput("buffered done count", longint'(nDone), 2);
    checkOutput("buffered period", longint'(secondAt - firstAt), 4);
    checkOutput("buffered d1", r1b, 1);
    checkOutput("buffered d2", r2b, 2);
    checkOutput("buffered dd", rdb, 1);
`else
    checkOutput("unbuffered done count", longint'(nDone), 1);
    checkOutput("unbuffered d1 hold", sx(d1), 15);
`endif

    // Start held in the done cycle gives a 5-cycle back-to-back period.
    nDone = 0; firstAt = 0; secondAt = 0;
    @(negedge clk);
    applyStimulus(1'b1, 32'd3, 32'd8, 32'd20);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1'b0, $urandom, $urandom, $urandom);
      if (k == 5) applyStimulus(1'b1, -32'sd7, 32'd0, 32'd7);
      if (k == 6) applyStimulus(1'b0, $urandom, $urandom, $urandom);
      if (done) begin
        nDone++;
        if (nDone == 1) firstAt = k;
        if (nDone == 2) begin secondAt = k; r1b = sx(d1); r2b = sx(d2); rdb = sx(dd); end
      end
    end
    checkOutput("b2b first done", longint'(firstAt), 5);
    checkOutput("b2b period", longint'(secondAt - firstAt), 5);
    checkOutput("b2b d1", r1b, 7);
    checkOutput("b2b d2", r2b, 7);
    checkOutput("b2b dd", rdb, 0);

    // Reset pulse during DD aborts the job without a done.
    @(negedge clk);
    applyStimulus(1'b1, 32'd7, 32'd3, 32'd20);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1'b0, $urandom, $urandom, $urandom);
    end
    rstn = 1'b0;
    #1;
    checkOutput("abort busy", longint'(busy), 0);
    checkOutput("abort done", longint'(done), 0);
    checkOutput("abort d1", sx(d1), 0);
    checkOutput("abort d2", sx(d2), 0);
    checkOutput("abort dd", sx(dd), 0);
    checkOutput("abort sub_en", longint'(sub_en), 0);
    #1 rstn = 1'b1;
    nDone = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) nDone++;
    end
    checkOutput("abort no done", longint'(nDone), 0);
    runJob("after abort", 32'd5, 32'd9, 32'd20, 64'sd4, 64'sd11, 64'sd7);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
